// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator input unit and display driver.
package calc_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_FULL  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [3:0] SIGN_NEG = 4'hE;
  localparam logic [3:0] SIGN_POS = 4'h0;

endpackage

// File: rtl/bcd_range_cmp.sv
// Combinational signed-magnitude range check against asymmetric limits.
module bcd_range_cmp #(
  parameter int unsigned MAG_W   = 10,
  parameter int unsigned MAX_POS = 127,
  parameter int unsigned MAX_NEG = 128
) (
  input  logic [MAG_W-1:0] mag,
  input  logic             neg,
  output logic             over_c
);

  logic [31:0] mag32;

  assign mag32  = 32'(mag);
  assign over_c = neg ? (mag32 > MAX_NEG) : (mag32 > MAX_POS);

endmodule

// File: rtl/bcd_entry_checker.sv
// Digit-serial signed BCD operand entry with range checking and commit hand-off.
module bcd_entry_checker
  import calc_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned MAX_POS    = 127,
  parameter int unsigned MAX_NEG    = 128,
  parameter int unsigned MAG_W      = $clog2(10**NUM_DIGITS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            digit_valid,
  input  logic [3:0]                      digit,
  input  logic                            sign_toggle,
  input  logic                            clear,
  input  logic                            commit,
  output logic [4*(NUM_DIGITS+1)-1:0]     bcd_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            full,
  output logic                            overflow,
  output logic [OUT_W-1:0]                bin_out,
  output logic                            value_valid,
  output logic                            error
);

  localparam int unsigned BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);

  if (MAX_POS >= 2**(OUT_W-1) || MAX_NEG > 2**(OUT_W-1)) begin : g_width_err
    $error("bcd_entry_checker: MAX_POS/MAX_NEG do not fit in OUT_W");
  end

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [OUT_W-1:0]   bin_d;
  logic [OUT_W-1:0]   mag_ext;
  logic               vv_d, err_d;
  logic               neg_q, neg_d;
  logic               over_c;

  assign neg_q   = (bcd_out[BCD_W-1 -: 4] == SIGN_NEG);
  assign neg_d   = (bcd_d[BCD_W-1 -: 4] == SIGN_NEG);
  assign mag_ext = OUT_W'(mag_q);

  bcd_range_cmp #(
    .MAG_W   (MAG_W),
    .MAX_POS (MAX_POS),
    .MAX_NEG (MAX_NEG)
  ) u_cmp (
    .mag    (mag_d),
    .neg    (neg_d),
    .over_c (over_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      bcd_out     <= '0;
      mag_q       <= '0;
      digit_count <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
      bin_out     <= '0;
      value_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_out     <= bcd_d;
      mag_q       <= mag_d;
      digit_count <= cnt_d;
      full        <= (cnt_d == CNT_W'(NUM_DIGITS));
      overflow    <= over_c;
      bin_out     <= bin_d;
      value_valid <= vv_d;
      error       <= err_d;
    end
  end

  // Next-state: only the highest-priority strobe acts
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_out;
    mag_d   = mag_q;
    cnt_d   = digit_count;
    bin_d   = bin_out;
    vv_d    = 1'b0;
    err_d   = 1'b0;

    if (clear) begin
      state_d = S_EMPTY;
      bcd_d   = '0;
      mag_d   = '0;
      cnt_d   = '0;
    end else if (commit) begin
      if (state_q == S_ERR || overflow) begin
        err_d   = 1'b1;
        state_d = S_ERR;
      end else begin
        vv_d    = 1'b1;
        bin_d   = neg_q ? (OUT_W'(0) - mag_ext) : mag_ext;
        state_d = S_EMPTY;
        bcd_d   = '0;
        mag_d   = '0;
        cnt_d   = '0;
      end
    end else if (sign_toggle) begin
      if (state_q != S_ERR) begin
        bcd_d[BCD_W-1 -: 4] = neg_q ? SIGN_POS : SIGN_NEG;
      end
    end else if (digit_valid && digit <= 4'd9 &&
                 (state_q == S_EMPTY || state_q == S_ENTRY)) begin
      // Leading zeros are not significant and leave the entry untouched
      if (!(state_q == S_EMPTY && digit == 4'd0)) begin
        bcd_d[DIG_W-1:0] = (bcd_out[DIG_W-1:0] << 4) | DIG_W'(digit);
        mag_d            = (mag_q * MAG_W'(10)) + MAG_W'(digit);
        cnt_d            = digit_count + CNT_W'(1);
        state_d          = (cnt_d == CNT_W'(NUM_DIGITS)) ? S_FULL : S_ENTRY;
      end
    end
  end

endmodule

// File: tb/tb_bcd_entry_checker.sv
// Directed table-driven check of bcd_entry_checker, default and 5-digit/16-bit instances.
module tb_bcd_entry_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (3 digits, 8-bit output)
  logic        rst, digit_valid, sign_toggle, clear, commit;
  logic [3:0]  digit;
  logic [15:0] bcd_out;
  logic [1:0]  digit_count;
  logic        full, overflow, value_valid, error;
  logic [7:0]  bin_out;

  bcd_entry_checker dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .sign_toggle(sign_toggle), .clear(clear), .commit(commit),
    .bcd_out(bcd_out), .digit_count(digit_count), .full(full),
    .overflow(overflow), .bin_out(bin_out), .value_valid(value_valid),
    .error(error)
  );

  // Wide instance (5 digits, 16-bit output)
  logic        b_rst, b_dv, b_tg, b_cl, b_cm;
  logic [3:0]  b_digit;
  logic [23:0] b_bcd;
  logic [2:0]  b_cnt;
  logic        b_full, b_ov, b_vv, b_err;
  logic [15:0] b_bin;

  bcd_entry_checker #(
    .NUM_DIGITS(5), .OUT_W(16), .MAX_POS(32767), .MAX_NEG(32768)
  ) dut_w (
    .clk(clk), .rst(b_rst), .digit_valid(b_dv), .digit(b_digit),
    .sign_toggle(b_tg), .clear(b_cl), .commit(b_cm),
    .bcd_out(b_bcd), .digit_count(b_cnt), .full(b_full),
    .overflow(b_ov), .bin_out(b_bin), .value_valid(b_vv), .error(b_err)
  );

  typedef struct {
    logic        rst, dv;
    logic [3:0]  d;
    logic        tg, cl, cm;
    logic [15:0] e_bcd;
    logic [1:0]  e_cnt;
    logic        e_full, e_ov;
    logic [7:0]  e_bin;
    logic        e_vv, e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic dv, input logic [3:0] d,
                     input logic tg, input logic cl, input logic cm,
                     input logic [15:0] eb, input logic [1:0] ec, input logic ef,
                     input logic eo, input logic [7:0] ebin, input logic ev,
                     input logic ee);
    vec_t v;
    v.rst = r; v.dv = dv; v.d = d; v.tg = tg; v.cl = cl; v.cm = cm;
    v.e_bcd = eb; v.e_cnt = ec; v.e_full = ef; v.e_ov = eo;
    v.e_bin = ebin; v.e_vv = ev; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic b_step(input logic r, input logic dv, input logic [3:0] d,
                        input logic tg, input logic cl, input logic cm);
    b_rst = r; b_dv = dv; b_digit = d; b_tg = tg; b_cl = cl; b_cm = cm;
    @(posedge clk); #1;
    b_rst = 0; b_dv = 0; b_digit = 0; b_tg = 0; b_cl = 0; b_cm = 0;
  endtask

  initial begin
    rst = 1; digit_valid = 0; digit = 0; sign_toggle = 0; clear = 0; commit = 0;
    b_rst = 1; b_dv = 0; b_digit = 0; b_tg = 0; b_cl = 0; b_cm = 0;

    //   rst dv d    tg cl cm  bcd       cnt full ov  bin    vv err
    add(1, 0, 4'd0, 0, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 4'd1, 0, 0, 0, 16'h0001, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 4'd2, 0, 0, 0, 16'h0012, 2, 0, 0, 8'h00, 0, 0);
    add(0, 1, 4'd7, 0, 0, 0, 16'h0127, 3, 1, 0, 8'h00, 0, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 8'h7F, 1, 0);
    add(0, 0, 4'd0, 0, 0, 0, 16'h0000, 0, 0, 0, 8'h7F, 0, 0);
    add(0, 1, 4'd1, 0, 0, 0, 16'h0001, 1, 0, 0, 8'h7F, 0, 0);
    add(0, 1, 4'd2, 0, 0, 0, 16'h0012, 2, 0, 0, 8'h7F, 0, 0);
    add(0, 1, 4'd8, 0, 0, 0, 16'h0128, 3, 1, 1, 8'h7F, 0, 0);
    add(0, 0, 4'd0, 1, 0, 0, 16'hE128, 3, 1, 0, 8'h7F, 0, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 8'h80, 1, 0);
    add(0, 1, 4'd1, 0, 0, 0, 16'h0001, 1, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd2, 0, 0, 0, 16'h0012, 2, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd9, 0, 0, 0, 16'h0129, 3, 1, 1, 8'h80, 0, 0);
    add(0, 0, 4'd0, 1, 0, 0, 16'hE129, 3, 1, 1, 8'h80, 0, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'hE129, 3, 1, 1, 8'h80, 0, 1);
    add(0, 1, 4'd5, 0, 0, 0, 16'hE129, 3, 1, 1, 8'h80, 0, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'hE129, 3, 1, 1, 8'h80, 0, 1);
    add(0, 0, 4'd0, 1, 0, 0, 16'hE129, 3, 1, 1, 8'h80, 0, 0);
    add(0, 0, 4'd0, 0, 1, 0, 16'h0000, 0, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd0, 0, 0, 0, 16'h0000, 0, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd0, 0, 0, 0, 16'h0000, 0, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd5, 0, 0, 0, 16'h0005, 1, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd3, 0, 0, 0, 16'h0053, 2, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd4, 0, 0, 0, 16'h0534, 3, 1, 1, 8'h80, 0, 0);
    add(0, 1, 4'd6, 0, 0, 0, 16'h0534, 3, 1, 1, 8'h80, 0, 0);
    add(0, 1, 4'd7, 0, 1, 0, 16'h0000, 0, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'hA, 0, 0, 0, 16'h0000, 0, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd5, 0, 0, 0, 16'h0005, 1, 0, 0, 8'h80, 0, 0);
    add(0, 1, 4'd0, 0, 0, 0, 16'h0050, 2, 0, 0, 8'h80, 0, 0);
    add(0, 0, 4'd0, 1, 0, 1, 16'h0000, 0, 0, 0, 8'h32, 1, 0);
    add(0, 0, 4'd0, 1, 0, 0, 16'hE000, 0, 0, 0, 8'h32, 0, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 8'h00, 1, 0);
    add(0, 1, 4'd3, 0, 0, 0, 16'h0003, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 4'd2, 0, 0, 0, 16'h0032, 2, 0, 0, 8'h00, 0, 0);
    add(0, 0, 4'd0, 1, 0, 0, 16'hE032, 2, 0, 0, 8'h00, 0, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 8'hE0, 1, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 8'h00, 1, 0);
    add(0, 1, 4'd4, 0, 0, 1, 16'h0000, 0, 0, 0, 8'h00, 1, 0);
    add(0, 1, 4'd3, 0, 0, 0, 16'h0003, 1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 8'h03, 1, 0);
    add(0, 1, 4'd9, 0, 0, 0, 16'h0009, 1, 0, 0, 8'h03, 0, 0);
    add(0, 1, 4'd9, 0, 0, 0, 16'h0099, 2, 0, 0, 8'h03, 0, 0);
    add(1, 1, 4'd9, 0, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; digit_valid = vecs[i].dv; digit = vecs[i].d;
      sign_toggle = vecs[i].tg; clear = vecs[i].cl; commit = vecs[i].cm;
      @(posedge clk); #1;
      chk("bcd_out",     i, 32'(bcd_out),     32'(vecs[i].e_bcd));
      chk("digit_count", i, 32'(digit_count), 32'(vecs[i].e_cnt));
      chk("full",        i, 32'(full),        32'(vecs[i].e_full));
      chk("overflow",    i, 32'(overflow),    32'(vecs[i].e_ov));
      chk("bin_out",     i, 32'(bin_out),     32'(vecs[i].e_bin));
      chk("value_valid", i, 32'(value_valid), 32'(vecs[i].e_vv));
      chk("error",       i, 32'(error),       32'(vecs[i].e_err));
    end
    rst = 0; digit_valid = 0; digit = 0; sign_toggle = 0; clear = 0; commit = 0;

    // Wide instance: 32768 overflows positive, error on commit, toggle frozen in error
    b_step(1, 0, 4'd0, 0, 0, 0);
    chk("w_reset_bcd", 0, 32'(b_bcd), 32'h0);
    b_step(0, 1, 4'd3, 0, 0, 0);
    b_step(0, 1, 4'd2, 0, 0, 0);
    b_step(0, 1, 4'd7, 0, 0, 0);
    b_step(0, 1, 4'd6, 0, 0, 0);
    b_step(0, 1, 4'd8, 0, 0, 0);
    chk("w_bcd",  1, 32'(b_bcd),  32'h032768);
    chk("w_cnt",  1, 32'(b_cnt),  32'd5);
    chk("w_full", 1, 32'(b_full), 32'd1);
    chk("w_ov",   1, 32'(b_ov),   32'd1);
    b_step(0, 0, 4'd0, 0, 0, 1);
    chk("w_err",  2, 32'(b_err),  32'd1);
    chk("w_vv",   2, 32'(b_vv),   32'd0);
    chk("w_bin",  2, 32'(b_bin),  32'h0);
    b_step(0, 0, 4'd0, 1, 0, 0);
    chk("w_tg_ignored", 3, 32'(b_bcd), 32'h032768);
    chk("w_ov_kept",    3, 32'(b_ov),  32'd1);
    chk("w_err_pulse",  3, 32'(b_err), 32'd0);
    // Negative 32768 is legal and commits as 16'h8000
    b_step(0, 0, 4'd0, 0, 1, 0);
    chk("w_clear", 4, 32'(b_bcd), 32'h0);
    b_step(0, 1, 4'd3, 0, 0, 0);
    b_step(0, 1, 4'd2, 0, 0, 0);
    b_step(0, 1, 4'd7, 0, 0, 0);
    b_step(0, 1, 4'd6, 0, 0, 0);
    b_step(0, 1, 4'd8, 0, 0, 0);
    b_step(0, 0, 4'd0, 1, 0, 0);
    chk("w_neg_bcd", 5, 32'(b_bcd), 32'hE32768);
    chk("w_neg_ov",  5, 32'(b_ov),  32'd0);
    b_step(0, 0, 4'd0, 0, 0, 1);
    chk("w_commit_bin", 6, 32'(b_bin), 32'h8000);
    chk("w_commit_vv",  6, 32'(b_vv),  32'd1);
    chk("w_commit_err", 6, 32'(b_err), 32'd0);
    chk("w_commit_bcd", 6, 32'(b_bcd), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_entry_checker.md
Name: bcd_entry_checker

Overview:
- Digit-serial operand entry and range checker for the calculator input unit.
- Accepts keypad digits one at a time, builds a signed BCD operand and its binary magnitude, and flags range overflow on every update.
- On commit, emits a two's-complement binary operand for the ALU.
- Generalises the fixed 3-digit/8-bit static check to N digits, configurable output width and asymmetric signed limits, with sign entry, clear and commit handshakes.

Parameters:
- NUM_DIGITS, 3, number of BCD magnitude digits accepted.
- OUT_W, 8, width of the two's-complement binary output.
- MAX_POS, 127, largest legal positive magnitude.
- MAX_NEG, 128, largest legal negative magnitude.
- MAG_W, $clog2(10**NUM_DIGITS), internal binary magnitude width (derived; do not override).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- digit_valid  in  1  one-cycle strobe; digit is sampled when high.
- digit  in  4  BCD digit 0-9.
- sign_toggle  in  1  one-cycle strobe; flips the operand sign.
- clear  in  1  one-cycle strobe; empties the entry.
- commit  in  1  one-cycle strobe; requests operand hand-off.
- bcd_out  out  4*(NUM_DIGITS+1)  sign nibble in the MS position (4'hE = negative, 4'h0 = positive), followed by the magnitude digits, MS digit first.
- digit_count  out  $clog2(NUM_DIGITS+1)  number of significant digits entered.
- full  out  1  digit_count == NUM_DIGITS.
- overflow  out  1  current entry is out of range.
- bin_out  out  OUT_W  last committed operand, two's complement; holds until the next successful commit.
- value_valid  out  1  one-cycle pulse on a successful commit.
- error  out  1  one-cycle pulse on a commit while overflow is set.

Behaviour:
- Reset values: every output is 0, sign is positive, magnitude is 0, state is S_EMPTY.
- States:
  - S_EMPTY: count == 0.
  - S_ENTRY: 0 < count < N.
  - S_FULL: count == N.
  - S_ERR: a commit was attempted with overflow set.
- Per-cycle priority: rst > clear > commit > sign_toggle > digit_valid. Only the highest-priority active request acts; lower ones in the same cycle are dropped.
- Digit accept:
  - Condition: state is S_EMPTY or S_ENTRY, and digit <= 9.
  - Action: shift the digit in at the LS position; mag <= mag*10 + digit; count++.
  - Leading zero: digit 0 in S_EMPTY is not counted, and nothing changes.
  - Ignored with no state change: digit > 9, state S_FULL, state S_ERR.
- Sign toggle: flips sign in S_EMPTY, S_ENTRY and S_FULL (-0 is allowed); ignored in S_ERR.
- Overflow:
  - Registered; overflow = sign ? (mag > MAX_NEG) : (mag > MAX_POS).
  - Computed from the next-state mag and sign, so it updates in the same cycle as bcd_out, one cycle after the strobe edge.
- Commit, overflow clear:
  - Next cycle: value_valid = 1 and bin_out = sign ? -mag : mag, truncated to OUT_W.
  - The entry is emptied (state S_EMPTY, bcd_out magnitude 0, sign positive, count 0).
  - -0 commits as 0.
- Commit, overflow set:
  - Next cycle: error = 1 and state becomes S_ERR.
  - Entry contents, bin_out and overflow are retained.
- Commit in S_EMPTY: commits 0 (value_valid pulses).
- S_ERR exits only via clear or rst, both of which go to S_EMPTY. A commit in S_ERR re-pulses error.
- clear: empties the entry and sets sign positive. It does not alter bin_out and produces no value_valid.
- Reset mid-entry: all state is discarded the next cycle, including bin_out.
- Latency: every strobe produces its effect on registered outputs exactly 1 cycle later. value_valid and error are never both high.
- Width rule: MAX_POS < 2**(OUT_W-1) and MAX_NEG <= 2**(OUT_W-1) are required; an elaboration-time assertion checks both.

Decomposition:
- calc_pkg holds the state enum (S_EMPTY, S_ENTRY, S_FULL, S_ERR) and the constants SIGN_NEG = 4'hE, SIGN_POS = 4'h0, shared with the display driver.
- One natural sub-module, bcd_range_cmp: a combinational compare of magnitude and sign against MAX_POS/MAX_NEG, reusable by the ALU result checker.

Test Plan:
- Digits 1,2,7 then commit (default parameters): bcd_out 16'h0127, overflow 0 before commit; after commit bin_out 8'h7F, value_valid pulses once, bcd_out 16'h0000.
- Digits 1,2,8: overflow 1. sign_toggle: bcd_out 16'hE128, overflow 0. Commit: bin_out 8'h80.
- Digits 1,2,9, toggle, commit: error pulses and state is S_ERR. Digit 5 then ignored (bcd_out stays 16'hE129). clear: bcd_out 16'h0000, bin_out unchanged.
- Digits 0,0,5,3,4,6: count 3 and full = 1 after the 4; 6 ignored; bcd_out 16'h0534, overflow 1.
- Same-cycle events: clear together with digit_valid=7 gives an empty result. digit=4'hA is ignored. commit together with sign_toggle commits the pre-toggle sign.
- rst asserted after digits 9,9: the next cycle shows all outputs 0. Instance with NUM_DIGITS=5, OUT_W=16, MAX_POS=32767, MAX_NEG=32768: entry 32768 then commit gives error; toggle is ignored in S_ERR.
